// File: rtl/sc_psrandom_checker.sv
// rtl/sc_psrandom_checker.sv - receive-side checker for the SC_PSRANDOM 8-bit LFSR word stream
//
// Purpose:
//   Self-synchronises to the generator's word stream (taps 7,5,3,0, shift-left),
//   declares lock after LOCK_MATCHES correctly predicted words, then flywheels
//   the reference and flags/counts every mismatched word. Lock is dropped after
//   LOSS_MISMATCHES consecutive mismatches.
//
// Build option:
//   SC_PSRANDOM_CHECKER_BITCOUNT_EN - when defined, the error counter advances by
//   the number of differing bits per mismatched word instead of by one.
//
// Ports:
//   SC_PSRANDOM_CLOCK_50                 in   system clock, posedge
//   SC_PSRANDOM_RESET_InHigh             in   asynchronous active-high reset
//   SC_PSRANDOM_CHECKER_valid_InHigh     in   data word qualifier
//   SC_PSRANDOM_CHECKER_data_InBUS       in   received generator word
//   SC_PSRANDOM_CHECKER_CLEAR_InHigh     in   synchronous clear of error count and zero flag
//   SC_PSRANDOM_CHECKER_lock_OutHigh     out  high while locked
//   SC_PSRANDOM_CHECKER_error_OutHigh    out  one-cycle pulse per mismatched word while locked
//   SC_PSRANDOM_CHECKER_errcount_OutBUS  out  saturating error count
//   SC_PSRANDOM_CHECKER_zero_OutHigh     out  sticky: an all-zero word was received

module sc_psrandom_checker #(
  parameter int RegGENERAL_DATAWIDTH = 8,
  parameter int LOCK_MATCHES         = 4,
  parameter int LOSS_MISMATCHES      = 3,
  parameter int ERRCNT_WIDTH         = 16
) (
  input  logic                            SC_PSRANDOM_CLOCK_50,
  input  logic                            SC_PSRANDOM_RESET_InHigh,
  input  logic                            SC_PSRANDOM_CHECKER_valid_InHigh,
  input  logic [RegGENERAL_DATAWIDTH-1:0] SC_PSRANDOM_CHECKER_data_InBUS,
  input  logic                            SC_PSRANDOM_CHECKER_CLEAR_InHigh,
  output logic                            SC_PSRANDOM_CHECKER_lock_OutHigh,
  output logic                            SC_PSRANDOM_CHECKER_error_OutHigh,
  output logic [ERRCNT_WIDTH-1:0]         SC_PSRANDOM_CHECKER_errcount_OutBUS,
  output logic                            SC_PSRANDOM_CHECKER_zero_OutHigh
);

  localparam int DW = RegGENERAL_DATAWIDTH;
  // Sum is computed wider than the counter so any per-word increment (up to 8)
  // can be detected as overflow before it is folded back to all-ones.
  localparam int SW = ERRCNT_WIDTH + 4;
  localparam logic [ERRCNT_WIDTH-1:0] ERR_MAX = {ERRCNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    SEARCH,
    TRAIN,
    LOCKED
  } state_t;

  state_t                state;
  logic [DW-1:0]         ref_word;
  logic [3:0]            matchcnt;
  logic [3:0]            misscnt;

  logic [DW-1:0]         expected;
  logic                  data_zero;
  logic                  mismatch;
  logic [3:0]            inc;
  logic [SW-1:0]         sum;
  logic [ERRCNT_WIDTH-1:0] errcount_next;

  // Generator next-word function: shift left, feedback from taps 7,5,3,0.
  function automatic logic [DW-1:0] step(input logic [DW-1:0] r);
    step = {r[DW-2:0], r[7] ^ r[5] ^ r[3] ^ r[0]};
  endfunction

  function automatic logic [3:0] popcount(input logic [DW-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < DW; i++) begin
      c = c + {3'd0, v[i]};
    end
    popcount = c;
  endfunction

  always_comb begin
    expected  = step(ref_word);
    data_zero = (SC_PSRANDOM_CHECKER_data_InBUS == '0);
    // The generator never emits zero, so a zero word is a mismatch even if the
    // reference were ever to predict one.
    mismatch  = (SC_PSRANDOM_CHECKER_data_InBUS != expected) || data_zero;
`ifdef SC_PSRANDOM_CHECKER_BITCOUNT_EN
    inc = popcount(SC_PSRANDOM_CHECKER_data_InBUS ^ expected);
`else
    inc = 4'd1;
`endif
    sum = SW'(SC_PSRANDOM_CHECKER_errcount_OutBUS) + SW'(inc);
    if (sum > SW'(ERR_MAX)) begin
      errcount_next = ERR_MAX;
    end else begin
      errcount_next = sum[ERRCNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge SC_PSRANDOM_CLOCK_50 or posedge SC_PSRANDOM_RESET_InHigh) begin
    if (SC_PSRANDOM_RESET_InHigh) begin
      state                               <= SEARCH;
      ref_word                            <= '0;
      matchcnt                            <= 4'd0;
      misscnt                             <= 4'd0;
      SC_PSRANDOM_CHECKER_lock_OutHigh    <= 1'b0;
      SC_PSRANDOM_CHECKER_error_OutHigh   <= 1'b0;
      SC_PSRANDOM_CHECKER_errcount_OutBUS <= '0;
      SC_PSRANDOM_CHECKER_zero_OutHigh    <= 1'b0;
    end else begin
      SC_PSRANDOM_CHECKER_error_OutHigh <= 1'b0;

      // Clear only touches the counter and the zero flag; a zero word arriving
      // in the same cycle as clear is dropped along with the history.
      if (SC_PSRANDOM_CHECKER_CLEAR_InHigh) begin
        SC_PSRANDOM_CHECKER_errcount_OutBUS <= '0;
        SC_PSRANDOM_CHECKER_zero_OutHigh    <= 1'b0;
      end else if (SC_PSRANDOM_CHECKER_valid_InHigh && data_zero) begin
        SC_PSRANDOM_CHECKER_zero_OutHigh    <= 1'b1;
      end

      if (SC_PSRANDOM_CHECKER_valid_InHigh) begin
        case (state)
          SEARCH: begin
            if (!data_zero) begin
              ref_word <= SC_PSRANDOM_CHECKER_data_InBUS;
              matchcnt <= 4'd0;
              state    <= TRAIN;
            end
          end

          TRAIN: begin
            // Training always re-seeds from the received word so a good run
            // can start from whatever word broke the previous one.
            ref_word <= SC_PSRANDOM_CHECKER_data_InBUS;
            if (!mismatch) begin
              matchcnt <= matchcnt + 4'd1;
              if (matchcnt + 4'd1 == 4'(LOCK_MATCHES)) begin
                state                            <= LOCKED;
                misscnt                          <= 4'd0;
                SC_PSRANDOM_CHECKER_lock_OutHigh <= 1'b1;
              end
            end else begin
              matchcnt <= 4'd0;
              if (data_zero) begin
                state <= SEARCH;
              end
            end
          end

          LOCKED: begin
            // Flywheel: the reference advances on its own so one corrupted
            // word costs exactly one error and does not poison the next.
            ref_word <= expected;
            if (!mismatch) begin
              misscnt <= 4'd0;
            end else begin
              SC_PSRANDOM_CHECKER_error_OutHigh <= 1'b1;
              if (!SC_PSRANDOM_CHECKER_CLEAR_InHigh) begin
                SC_PSRANDOM_CHECKER_errcount_OutBUS <= errcount_next;
              end
              misscnt <= misscnt + 4'd1;
              if (misscnt + 4'd1 == 4'(LOSS_MISMATCHES)) begin
                state                            <= SEARCH;
                SC_PSRANDOM_CHECKER_lock_OutHigh <= 1'b0;
              end
            end
          end

          default: begin
            state                            <= SEARCH;
            SC_PSRANDOM_CHECKER_lock_OutHigh <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sc_psrandom_checker.md
# sc_psrandom_checker

Receive-side checker for the 8-bit pseudo-random word stream produced by the team's SC_PSRANDOM LFSR generator (taps 7,5,3,0; shift-left, one bit per clock). It self-synchronises to the incoming words, declares lock after a run of correctly predicted words, and then flags and counts mismatches. It sits at the far end of a link or datapath fed by the generator, providing built-in self-test of that path.

## Interface

- RegGENERAL_DATAWIDTH, 8, word width; only 8 is supported because the taps are fixed.
- LOCK_MATCHES, 4, consecutive correct predictions needed to enter LOCKED (1..15).
- LOSS_MISMATCHES, 3, consecutive mismatches in LOCKED that drop lock (1..15).
- ERRCNT_WIDTH, 16, width of the error counter.

Ports:

- SC_PSRANDOM_CLOCK_50  in  1  system clock; all logic on posedge.
- SC_PSRANDOM_RESET_InHigh  in  1  reset, asynchronous, active-high.
- SC_PSRANDOM_CHECKER_valid_InHigh  in  1  data word qualifier; state holds while low.
- SC_PSRANDOM_CHECKER_data_InBUS  in  8  received generator word.
- SC_PSRANDOM_CHECKER_CLEAR_InHigh  in  1  synchronous clear of the error counter and the zero flag.
- SC_PSRANDOM_CHECKER_lock_OutHigh  out  1  high while in LOCKED.
- SC_PSRANDOM_CHECKER_error_OutHigh  out  1  one-cycle pulse per mismatched word while LOCKED.
- SC_PSRANDOM_CHECKER_errcount_OutBUS  out  ERRCNT_WIDTH  saturating error count.
- SC_PSRANDOM_CHECKER_zero_OutHigh  out  1  sticky flag: an all-zero word was received.

## Operation

- Next-word function: step(r) = {r[6:0], r[7]^r[5]^r[3]^r[0]}.
- Internal registers:
  - ref: 8-bit reference word.
  - matchcnt and misscnt: 4-bit counters.
  - state: SEARCH, TRAIN or LOCKED.
- Only cycles with valid=1 act. When valid=0, all state, counters and ref hold, and error is 0.

SEARCH:
- Nonzero word: ref←data, matchcnt←0, go to TRAIN.
- Zero word: stay in SEARCH; zero flag set.

TRAIN:
- data==step(ref) and data≠0: matchcnt+1, ref←data.
  - If matchcnt+1==LOCK_MATCHES: go to LOCKED, misscnt←0.
- Otherwise (mismatch): matchcnt←0, ref←data. A zero word returns to SEARCH.
- No errors are counted in SEARCH or TRAIN.

LOCKED (flywheel):
- ref←step(ref) every valid cycle, regardless of the received word, so a single corrupted word costs exactly one error.
- Match: misscnt←0.
- Mismatch: error pulse, errcount increment, misscnt+1.
  - If misscnt+1==LOSS_MISMATCHES: go to SEARCH.
  - The word causing loss of lock is still counted.
- An all-zero word is always a mismatch in LOCKED and also sets the zero flag.

Error counter:
- Saturates at all-ones and never wraps.
- CLEAR has priority over a coincident increment: the counter becomes 0 and that error is not counted, but the error pulse still fires.
- CLEAR does not affect state, lock or ref.

## Timing

- All outputs are registered. Reset values: lock=0, error=0, errcount=0, zero=0, state=SEARCH, ref=0, matchcnt=0, misscnt=0.
- lock rises on the clock edge that samples the LOCK_MATCHES-th matching word, so it is visible one cycle after that word is presented.
- lock falls on the edge sampling the LOSS_MISMATCHES-th consecutive mismatch.
- error and errcount update on the edge that samples the offending word. error lasts exactly one cycle unless the next valid word also mismatches.
- Back-to-back valid words are supported at full rate with no bubbles.
- Reset mid-operation: immediate return to the reset values; relock requires the full SEARCH/TRAIN sequence.

## Configuration

- SC_PSRANDOM_CHECKER_BITCOUNT_EN:
  - Defined: errcount increments by popcount(data ^ step(ref)), 1..8 per mismatched word, saturating.
  - Undefined: errcount increments by 1 per mismatched word.
- error pulse, lock behaviour and misscnt are identical in both builds.

## Test plan

- Lock: after reset, feed 0x85,0x0A,0x15,0x2B,0x57 with LOCK_MATCHES=4 -> lock=0 through 0x2B, lock=1 the cycle after 0x57, errcount=0.
- Single corruption: continue with 0xAE (expected 0xAF), then 0x5E -> one error pulse, errcount=1 in both builds (one bit differs), no error on 0x5E, lock stays 1.
- Loss of lock: from LOCKED, feed three wrong words (0x00,0x33,0x33) -> three error pulses, zero=1, lock=0 after the third, errcount=3 (word build).
- Valid gaps and clear: locked stream with valid toggling 1/0 -> no errors, state frozen during gaps. CLEAR coincident with a mismatch -> errcount=0, error pulse still seen.
- Saturation and bit mode: with ERRCNT_WIDTH=4 and _BITCOUNT_EN defined, inject 0x50 instead of 0xAF (8 bits differ) twice -> errcount=8 then 15, holding at 15.
- Async reset: assert reset while locked mid-cycle -> all outputs 0 immediately; relock needs 5 valid words.
